// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, parity helper and default timing constants.
package ps2_pkg;

   localparam int RTS_CYCLES_DEF     = 5000;
   localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
   localparam int FILTER_LEN_DEF     = 8;
   localparam int CNT_W              = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RTS,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_ACK,
      ST_RELEASE
   } ps2_tx_state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between a controller and the PS/2 transmitter.
interface ps2_tx_if;
   logic       wr_ps2;
   logic [7:0] din;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err;

   modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err);
   modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err);
endinterface

// File: rtl/ps2_edge_filter.sv
// PS/2 clock deglitcher: the filtered level only moves once FILTER_LEN samples agree.
module ps2_edge_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c_in,
   output logic filt,
   output logic fall
);

   logic [FILTER_LEN-1:0] sr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '1;
         filt <= 1'b1;
         fall <= 1'b0;
      end else begin
         sr   <= {sr[FILTER_LEN-2:0], ps2c_in};
         fall <= 1'b0;
         if (&sr) begin
            filt <= 1'b1;
         end else if (~|sr) begin
            filt <= 1'b0;
            fall <= filt;
         end
      end
   end

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame, device ACK check and watchdog.
//   state      | meaning
//   ST_IDLE    | lines released, waiting for wr_ps2
//   ST_RTS     | holding clock low for the request-to-send interval
//   ST_START   | data low (start bit), waiting for first device clock
//   ST_DATA    | shifting out 8 data bits then parity
//   ST_STOP    | data released (stop bit)
//   ST_ACK     | waiting for device ACK clock, sampling data
//   ST_RELEASE | waiting for both lines to go high
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
   input  logic     clk,
   input  logic     reset,
   ps2_tx_if.slave  bus,
   input  logic     ps2c_in,
   input  logic     ps2d_in,
   output logic     ps2c_oe,
   output logic     ps2d_oe
);

   localparam logic [CNT_W-1:0] RTS_LOAD = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   ps2_tx_state_t    state;
   logic [8:0]       b;
   logic [3:0]       n;
   logic [CNT_W-1:0] cnt;
   logic             tx_idle_r;
   logic             done_r;
   logic             err_r;
   logic             filt;
   logic             fall;

   ps2_edge_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk     (clk),
      .reset   (reset),
      .ps2c_in (ps2c_in),
      .filt    (filt),
      .fall    (fall)
   );

   assign bus.tx_idle      = tx_idle_r;
   assign bus.tx_done_tick = done_r;
   assign bus.tx_err       = err_r;

   // cnt is the RTS down-counter in ST_RTS and the inter-edge watchdog afterwards
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         b         <= '0;
         n         <= '0;
         cnt       <= '0;
         ps2c_oe   <= 1'b0;
         ps2d_oe   <= 1'b0;
         tx_idle_r <= 1'b1;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.wr_ps2) begin
                  b         <= {odd_parity(bus.din), bus.din};
                  err_r     <= 1'b0;
                  cnt       <= RTS_LOAD;
                  tx_idle_r <= 1'b0;
                  ps2c_oe   <= 1'b1;
                  state     <= ST_RTS;
               end
            end
            ST_RTS: begin
               if (cnt == '0) begin
                  ps2c_oe <= 1'b0;
                  ps2d_oe <= 1'b1;
                  state   <= ST_START;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               if (state == ST_RELEASE && filt && ps2d_in) begin
                  done_r    <= 1'b1;
                  tx_idle_r <= 1'b1;
                  state     <= ST_IDLE;
               end else if (fall) begin
                  cnt <= '0;
                  case (state)
                     ST_START: begin
                        n       <= 4'd8;
                        ps2d_oe <= ~b[0];
                        state   <= ST_DATA;
                     end
                     ST_DATA: begin
                        b <= {1'b0, b[8:1]};
                        if (n == 4'd0) begin
                           ps2d_oe <= 1'b0;
                           state   <= ST_STOP;
                        end else begin
                           n       <= n - 4'd1;
                           ps2d_oe <= ~b[1];
                        end
                     end
                     ST_STOP: state <= ST_ACK;
                     ST_ACK: begin
                        err_r <= ps2d_in;
                        state <= ST_RELEASE;
                     end
                     default: ;
                  endcase
               end else if (cnt == TO_LAST) begin
                  ps2c_oe   <= 1'b0;
                  ps2d_oe   <= 1'b0;
                  err_r     <= 1'b1;
                  done_r    <= 1'b1;
                  tx_idle_r <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames in and the captured bits are compared with a byte-level model.
module tb_ps2_tx;

   localparam int RTS  = 5000;
   localparam int TOUT = 2000;
   localparam int FLEN = 8;
   localparam int HALF = 60;

   logic clk = 1'b0;
   logic reset;
   logic ps2c_oe, ps2d_oe;
   logic dev_c_low = 1'b0;
   logic dev_d_low = 1'b0;
   logic ps2c_in, ps2d_in;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   logic err_at_done = 1'b0;

   ps2_tx_if bus();

   assign ps2c_in = ~(ps2c_oe | dev_c_low);
   assign ps2d_in = ~(ps2d_oe | dev_d_low);

   ps2_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TOUT), .FILTER_LEN(FLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .ps2c_in (ps2c_in),
      .ps2d_in (ps2d_in),
      .ps2c_oe (ps2c_oe),
      .ps2d_oe (ps2d_oe)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (bus.tx_done_tick === 1'b1) begin
         done_cnt++;
         done_cyc    = cyc;
         err_at_done = bus.tx_err;
      end
   end

   function automatic logic [9:0] expect_frame(input logic [7:0] d);
      logic par;
      par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, d};
   endfunction

   // Device side: detect request-to-send, then clock nclk cycles, sampling data at the end of each low phase.
   task automatic dev_frame(input bit ack, input int nclk, input int glitch_at,
                            output logic [9:0] cap, output bit ok);
      int t;
      cap = '0;
      ok  = 1'b1;
      t = 0;
      while (ps2c_in !== 1'b0 && t < 20000) begin @(negedge clk); t++; end
      if (t >= 20000) ok = 1'b0;
      t = 0;
      while (!(ps2c_in === 1'b1 && ps2d_in === 1'b0) && t < 20000) begin @(negedge clk); t++; end
      if (t >= 20000) ok = 1'b0;
      if (ok) begin
         repeat (20) @(negedge clk);
         for (int i = 1; i <= nclk; i++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (i <= 10) cap[i-1] = ps2d_in;
            dev_c_low = 1'b0;
            if (i == 10 && ack) dev_d_low = 1'b1;
            if (i == glitch_at) begin
               repeat (20) @(negedge clk);
               dev_c_low = 1'b1;
               repeat (5) @(negedge clk);
               dev_c_low = 1'b0;
               repeat (HALF - 25) @(negedge clk);
            end else begin
               repeat (HALF) @(negedge clk);
            end
         end
         dev_d_low = 1'b0;
      end
   endtask

   task automatic strobe(input logic [7:0] d);
      @(negedge clk);
      bus.din    = d;
      bus.wr_ps2 = 1'b1;
      @(negedge clk);
      bus.wr_ps2 = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 20000) begin @(negedge clk); t++; end
      total++;
      if (done_cnt == d0) begin
         bad++;
         $display("FAIL %s done_wait: no tx_done_tick within %0d cycles", name, t);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.wr_ps2 = 1'b0;
      bus.din = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (ps2c_oe !== 1'b0) begin bad++; $display("FAIL rst_c_oe got=%b exp=0", ps2c_oe); end
      total++; if (ps2d_oe !== 1'b0) begin bad++; $display("FAIL rst_d_oe got=%b exp=0", ps2d_oe); end
      total++; if (bus.tx_idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", bus.tx_idle); end
      total++; if (bus.tx_done_tick !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.tx_done_tick); end
      total++; if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.tx_err); end
   endtask

   task automatic test_frame(input logic [7:0] d, input bit ack, input int glitch_at, input string name);
      logic [9:0] cap;
      bit ok;
      int rts_len;
      int d0;
      d0 = done_cnt;
      rts_len = 0;
      fork
         dev_frame(ack, 12, glitch_at, cap, ok);
         begin
            strobe(d);
            while (ps2c_oe === 1'b1 && rts_len < 10000) begin rts_len++; @(negedge clk); end
         end
      join
      wait_done(d0, name);
      total++; if (!ok) begin bad++; $display("FAIL %s dev_start: device never saw request", name); end
      total++; if (rts_len != RTS) begin bad++; $display("FAIL %s rts_len got=%0d exp=%0d", name, rts_len, RTS); end
      total++; if (cap !== expect_frame(d)) begin bad++; $display("FAIL %s frame got=%h exp=%h", name, cap, expect_frame(d)); end
      total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL %s done_count got=%0d exp=%0d", name, done_cnt - d0, 1); end
      total++; if (err_at_done !== !ack) begin bad++; $display("FAIL %s err got=%b exp=%b", name, err_at_done, !ack); end
      total++; if (bus.tx_idle !== 1'b1) begin bad++; $display("FAIL %s idle_after got=%b exp=1", name, bus.tx_idle); end
      total++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin bad++; $display("FAIL %s oe_after got=%b exp=00", name, {ps2c_oe, ps2d_oe}); end
   endtask

   task automatic test_random(input int count);
      logic [7:0] d;
      for (int i = 0; i < count; i++) begin
         d = 8'($urandom_range(0, 255));
         test_frame(d, 1'b1, 0, "random");
      end
   endtask

   task automatic test_timeout();
      logic [9:0] cap;
      bit ok;
      int t;
      int start_cyc;
      int d0;
      d0 = done_cnt;
      start_cyc = 0;
      fork
         dev_frame(1'b1, 0, 0, cap, ok);
         begin
            strobe(8'hA5);
            t = 0;
            while (ps2d_oe !== 1'b1 && t < 10000) begin @(negedge clk); t++; end
            start_cyc = cyc;
         end
      join
      wait_done(d0, "timeout");
      total++; if (done_cyc - start_cyc != TOUT) begin bad++; $display("FAIL timeout_len got=%0d exp=%0d", done_cyc - start_cyc, TOUT); end
      total++; if (err_at_done !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", err_at_done); end
      total++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin bad++; $display("FAIL timeout_oe got=%b exp=00", {ps2c_oe, ps2d_oe}); end
      total++; if (bus.tx_idle !== 1'b1) begin bad++; $display("FAIL timeout_idle got=%b exp=1", bus.tx_idle); end
   endtask

   task automatic test_ignored_wr();
      logic [9:0] cap;
      bit ok;
      int d0;
      logic idle_mid;
      d0 = done_cnt;
      idle_mid = 1'b1;
      fork
         dev_frame(1'b1, 12, 0, cap, ok);
         begin
            strobe(8'hED);
            repeat (5400) @(negedge clk);
            bus.din    = 8'hF4;
            bus.wr_ps2 = 1'b1;
            @(negedge clk);
            bus.wr_ps2 = 1'b0;
            idle_mid = bus.tx_idle;
         end
      join
      wait_done(d0, "ignored_wr");
      total++; if (idle_mid !== 1'b0) begin bad++; $display("FAIL ignored_wr idle_mid got=%b exp=0", idle_mid); end
      total++; if (cap !== expect_frame(8'hED)) begin bad++; $display("FAIL ignored_wr frame got=%h exp=%h", cap, expect_frame(8'hED)); end
      total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL ignored_wr done_count got=%0d exp=1", done_cnt - d0); end
      repeat (200) @(negedge clk);
      total++; if (bus.tx_idle !== 1'b1 || ps2c_oe !== 1'b0) begin bad++; $display("FAIL ignored_wr no_queue idle=%b c_oe=%b exp idle=1 c_oe=0", bus.tx_idle, ps2c_oe); end
   endtask

   task automatic test_reset_mid();
      logic [9:0] cap;
      bit ok;
      int d0;
      d0 = done_cnt;
      fork
         dev_frame(1'b1, 4, 0, cap, ok);
         strobe(8'hED);
      join
      @(negedge clk);
      #3 reset = 1'b1;
      #1;
      total++; if ({ps2c_oe, ps2d_oe} !== 2'b00) begin bad++; $display("FAIL reset_mid oe got=%b exp=00", {ps2c_oe, ps2d_oe}); end
      total++; if (bus.tx_idle !== 1'b1) begin bad++; $display("FAIL reset_mid idle got=%b exp=1", bus.tx_idle); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (50) @(negedge clk);
      total++; if (done_cnt != d0) begin bad++; $display("FAIL reset_mid done_count got=%0d exp=0", done_cnt - d0); end
   endtask

   initial begin
      test_reset();
      test_frame(8'hED, 1'b1, 0, "ed_ack");
      test_frame(8'h01, 1'b1, 0, "par_01");
      test_frame(8'h00, 1'b1, 0, "par_00");
      test_random(3);
      test_frame(8'h5A, 1'b0, 0, "nack");
      test_timeout();
      test_ignored_wr();
      test_reset_mid();
      test_frame(8'hED, 1'b1, 4, "glitch");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
